// File: rtl/piso_8bit_framer.sv
// Parallel-in/serial-out async-serial framer: start, 8 data bits LSB-first, optional even parity, stop.
// Define PISO_PARITY_EN to compile in the parity bit (frame grows from 10 to 11 bit periods).
module piso_8bit_framer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       Synch_clr,
    input  logic [7:0] D,
    input  logic       Load,
    output logic       Tx,
    output logic       Busy,
    output logic       Done
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PISO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             bit_end;

`ifdef PISO_PARITY_EN
    // Parity taken at capture time since the shift register is consumed as bits go out.
    logic par;
    always_ff @(posedge CLK) begin
        if (Synch_clr)                    par <= 1'b0;
        else if (state == S_IDLE && Load) par <= ^D;
    end
`endif

    assign bit_end = (div == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (Synch_clr) begin
            state   <= S_IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            Tx      <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            Tx      <= tx_nxt;
            Busy    <= busy_nxt;
            Done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = bit_end ? '0 : div + DIV_W'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        case (state)
            S_IDLE: begin
                div_nxt = '0;
                if (Load) begin
                    shift_nxt = D;
                    state_nxt = S_START;
                end
            end
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA: if (bit_end) begin
                shift_nxt = {1'b0, shift[7:1]};
                bit_nxt   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
`ifdef PISO_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
            S_STOP: if (bit_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from where the FSM is heading.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state == S_STOP) && (state_nxt == S_IDLE);
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_nxt[0];
`ifdef PISO_PARITY_EN
            S_PARITY: tx_nxt = par;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_piso_8bit_framer.sv
// Directed bench for piso_8bit_framer: N=4 instance for most scenarios, N=1 instance for the fast case.
module tb_piso_8bit_framer;
`ifdef PISO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       CLK = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] d_r = 8'd0;
    logic       load_r = 1'b0;
    logic       sel = 1'b0;
    logic       tx4, busy4, done4, tx1, busy1, done1;
    logic       load4, load1;
    int         total = 0;
    int         passes = 0;

    assign load4 = sel ? 1'b0 : load_r;
    assign load1 = sel ? load_r : 1'b0;

    piso_8bit_framer #(.CLKS_PER_BIT(4)) dut4 (
        .CLK(CLK), .Synch_clr(clr), .D(d_r), .Load(load4),
        .Tx(tx4), .Busy(busy4), .Done(done4)
    );
    piso_8bit_framer #(.CLKS_PER_BIT(1)) dut1 (
        .CLK(CLK), .Synch_clr(clr), .D(d_r), .Load(load1),
        .Tx(tx1), .Busy(busy1), .Done(done1)
    );

    always #5 CLK = ~CLK;

    function automatic logic obs_tx();   return sel ? tx1   : tx4;   endfunction
    function automatic logic obs_busy(); return sel ? busy1 : busy4; endfunction
    function automatic logic obs_done(); return sel ? done1 : done4; endfunction

    // Expected line level for serial bit slot b of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && NB == 11) return ^d;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller raises Load before calling; the first tick here is the accepting edge k.
    // Checks every cycle k..k+F-1, the Done edge k+F. poke>=0 re-pulses Load with D=127 mid-frame.
    task automatic frame_check(input logic [7:0] d, input int n, input bit keep_load,
                               input int poke, input string tag);
        int f;
        f = NB * n;
        for (int j = 0; j < f; j++) begin
            tick();
            if (j == 0 && !keep_load) load_r = 1'b0;
            if (poke >= 0 && j == poke) begin d_r = 8'd127; load_r = 1'b1; end
            if (poke >= 0 && j == poke + 1) load_r = 1'b0;
            chk($sformatf("%s tx c%0d", tag, j), 32'(obs_tx()), 32'(exp_bit(d, j / n)));
            chk($sformatf("%s busy c%0d", tag, j), 32'(obs_busy()), 32'd1);
            chk($sformatf("%s done c%0d", tag, j), 32'(obs_done()), 32'd0);
        end
        tick();
        chk({tag, " end busy"}, 32'(obs_busy()), 32'd0);
        chk({tag, " end done"}, 32'(obs_done()), 32'd1);
        chk({tag, " end tx"},   32'(obs_tx()),   32'd1);
    endtask

    initial begin
        int dcnt;
        // Reset held two edges with Load high: nothing may start.
        clr = 1'b1; load_r = 1'b1; d_r = 8'd26;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst tx", 32'(tx4), 32'd1);
            chk("rst busy", 32'(busy4), 32'd0);
            chk("rst done", 32'(done4), 32'd0);
        end
        clr = 1'b0; load_r = 1'b0;
        tick();
        chk("post-rst busy", 32'(busy4), 32'd0);
        chk("post-rst tx", 32'(tx4), 32'd1);

        // D=26 single frame; spot-check a hand-computed bit (data bit 1 = 1 at cycle 8).
        d_r = 8'd26; load_r = 1'b1;
        frame_check(8'd26, 4, 1'b0, -1, "d26");
        tick();
        chk("d26 done clears", 32'(done4), 32'd0);
        chk("d26 idle busy", 32'(busy4), 32'd0);

        // D=128 with D=127 + Load re-pulsed mid-frame.
        d_r = 8'd128; load_r = 1'b1;
        frame_check(8'd128, 4, 1'b0, 13, "d128");
        dcnt = 0;
        for (int i = 0; i < 3 * NB * 4; i++) begin
            tick();
            if (done4 || busy4) dcnt++;
        end
        chk("d128 no second frame", 32'(dcnt), 32'd0);

        // Load held high, D=255: back-to-back frames, one idle cycle between.
        d_r = 8'd255; load_r = 1'b1;
        frame_check(8'd255, 4, 1'b1, -1, "b2b0");
        frame_check(8'd255, 4, 1'b1, -1, "b2b1");
        frame_check(8'd255, 4, 1'b0, -1, "b2b2");
        tick();
        chk("b2b stop idle", 32'(busy4), 32'd0);

        // Abort during data bit 3 of D=129 (bit 3 spans cycles 16..19).
        d_r = 8'd129; load_r = 1'b1;
        for (int j = 0; j < 18; j++) begin
            tick();
            load_r = 1'b0;
            chk($sformatf("abort pre tx c%0d", j), 32'(tx4), 32'(exp_bit(8'd129, j / 4)));
        end
        clr = 1'b1; load_r = 1'b1;
        tick();
        chk("abort tx", 32'(tx4), 32'd1);
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        clr = 1'b0; load_r = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done4 || busy4 || !tx4) dcnt++;
        end
        chk("abort stays idle", 32'(dcnt), 32'd0);
        d_r = 8'd127; load_r = 1'b1;
        frame_check(8'd127, 4, 1'b0, -1, "after-abort");

        // CLKS_PER_BIT=1 instance.
        tick();
        sel = 1'b1;
        d_r = 8'd26; load_r = 1'b1;
        frame_check(8'd26, 1, 1'b0, -1, "n1");
        tick();
        chk("n1 done clears", 32'(done1), 32'd0);
        chk("n1 idle tx", 32'(tx1), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
